// File: rtl/dec_counter_multi.sv
// Multi-digit BCD decade counter with up/down count, parallel load and ripple carry.
// The output is re-encoded per digit as 8421, 2421 Aiken or excess-3 under runtime mode control.
module dec_counter_multi #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [1:0]            mode,
  output logic [4*DIGITS-1:0]   out,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam logic [3:0] DIG_MAX = 4'd9;

  logic [DIGITS-1:0][3:0] state_q, state_d;
  logic                   wrap_q, wrap_d;
  logic                   load_err_q, load_err_d;
  logic                   all9_c, all0_c;
  logic                   carry_c;
  logic [3:0]             ld_dig_c;

  // Terminal-value detection across all digits
  always_comb begin
    all9_c = 1'b1;
    all0_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (state_q[i] != DIG_MAX) all9_c = 1'b0;
      if (state_q[i] != 4'd0)    all0_c = 1'b0;
    end
  end

  assign tc = en & ((up & all9_c) | (~up & all0_c));

  // Next state: load beats count; carry/borrow ripples through all digits in one cycle
  always_comb begin
    state_d    = state_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    carry_c    = 1'b1;
    ld_dig_c   = 4'd0;
    if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        ld_dig_c = load_val[4*i +: 4];
        if (ld_dig_c > DIG_MAX) begin
          state_d[i] = 4'd0;
          load_err_d = 1'b1;
        end else begin
          state_d[i] = ld_dig_c;
        end
      end
    end else if (en) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (carry_c) begin
          if (up) begin
            if (state_q[i] == DIG_MAX) begin
              state_d[i] = 4'd0;
            end else begin
              state_d[i] = state_q[i] + 4'd1;
              carry_c    = 1'b0;
            end
          end else begin
            if (state_q[i] == 4'd0) begin
              state_d[i] = DIG_MAX;
            end else begin
              state_d[i] = state_q[i] - 4'd1;
              carry_c    = 1'b0;
            end
          end
        end
      end
      wrap_d = up ? all9_c : all0_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

  // Per-digit output encoding, combinational so a mode change shows immediately
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      case (mode)
        2'b01:   out[4*i +: 4] = (state_q[i] < 4'd5) ? state_q[i] : state_q[i] + 4'd6;
        2'b10:   out[4*i +: 4] = state_q[i] + 4'd3;
        default: out[4*i +: 4] = state_q[i];
      endcase
    end
  end

endmodule

// File: doc/dec_counter_multi.md
# dec_counter_multi

Parametrised multi-digit decade counter, the successor to the single-digit 2421 counter. Holds DIGITS decimal digits internally as BCD and counts up or down with enable, parallel load and ripple carry/borrow across digits. A runtime mode selects the output code (8421 BCD, 2421 Aiken or excess-3). It provides terminal-count and wrap flags so several instances can be cascaded or drive a display/timer stage.

## Interface
- DIGITS, 4: number of decimal digits (1..8); state and output width = 4*DIGITS.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  load value, BCD per digit, digit 0 in [3:0].
- mode  in  2  output code: 00 = 8421, 01 = 2421 Aiken, 10 = excess-3, 11 = treated as 8421.
- out  out  4*DIGITS  count, encoded per mode, digit 0 in [3:0].
- tc  out  1  terminal count (combinational).
- wrap  out  1  registered one-cycle pulse when the counter wrapped.
- load_err  out  1  registered one-cycle pulse when a load digit was invalid.

## Operation
- Internal state is a register of DIGITS BCD digits. Each digit is always in the range 0..9.
- Priority per rising edge: rst low > load > en > hold.
- Reset (rst = 0):
  - All digits are set to 0; wrap = 0; load_err = 0.
  - out reset value per digit: 0000 in 8421 and 2421, 0011 in excess-3.
- Load:
  - state <= load_val. Any digit above 9 is replaced by 0.
  - load_err = 1 next cycle if any digit was replaced, else 0.
  - Load takes effect regardless of en.
  - wrap = 0 in a load cycle.
- Count up (en = 1, up = 1):
  - Digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - All digits at 9 -> all 0, and wrap = 1 next cycle.
- Count down (en = 1, up = 0):
  - Digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - All digits at 0 -> all 9, and wrap = 1 next cycle.
- Hold: state unchanged; wrap = 0; load_err = 0.
- Output encoding, combinational from state and mode, applied per digit d:
  - 8421: d.
  - 2421: d for 0..4; d+6 for 5..9, giving 1011, 1100, 1101, 1110, 1111.
  - excess-3: d+3.
- tc = en & ((up & all digits 9) | (~up & all digits 0)).
  - Usable as en for the next cascaded instance.
  - tc is not gated by load.
- Codes 1010..1111 never appear in state. 2421 codes 0101..1010 never appear on out.

## Timing
- Count and load latency: state, and therefore out, updates on the same rising edge. out is valid one clk after the strobe.
- mode change: out re-encodes combinationally with zero-cycle latency. State is unaffected.
- wrap and load_err are registered. They are high exactly the one cycle after the causing edge and are cleared on the following edge unless the cause repeats.
- Continuous en at a terminal value wraps every 10^DIGITS cycles. wrap pulses once per wrap.
- Reset mid-count has priority over simultaneous load/en. The pending wrap and load_err are cleared.
- Direction changes take effect on the next enabled edge. No extra cycles are inserted.
- No multicycle paths; carry chain is combinational across DIGITS digits within one cycle.

## Test plan
- Reset and encoding (DIGITS = 2):
  - rst = 0 for one edge, then hold -> out = 0x00 in mode 00, 0x00 in mode 01, 0x33 in mode 10.
  - wrap = 0 and load_err = 0.
- Up-count with Aiken carry (mode 01):
  - en = 1, up = 1 from 0 for 15 cycles -> out sequence includes 0x04 -> 0x0B -> 0x0C -> 0x0D -> 0x0E -> 0x0F -> 0x10 -> 0x11.
  - After 15 edges, out = 0x1B.
- Wrap up (8421):
  - load_val = 0x99, then en = 1, up = 1 -> tc = 1 while state is 99.
  - Next edge: out = 0x00, and wrap = 1 for exactly one cycle.
- Wrap down (excess-3):
  - load 0x00, then en = 1, up = 0 -> out = 0xCC (state 99) after one edge.
  - wrap pulses; the next edge gives out = 0xCB.
- Invalid load and priority:
  - load = 1, en = 1, load_val = 0x5C -> state 50 and load_err = 1 for one cycle.
  - Asserting rst = 0 simultaneously instead -> state 00 and load_err = 0.
- Cascade:
  - Two DIGITS = 1 instances, the second's en tied to the first's tc, the first with en = 1 and up = 1.
  - After 25 edges from reset -> upper = 2, lower = 5 (8421).
